// File: rtl/nn_input_loader_pkg.sv
// Shared network package: loader FSM encoding, default sample width and state helpers.
package nn_input_loader_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_REQ   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // States in which the loader can take a sample from upstream.
    function automatic logic state_ready(input state_t s);
        return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/nn_input_loader.sv
// Streams one frame of signed samples into the network input memory, then
// hands off to the network with a request/acknowledge pair.
module nn_input_loader
    import nn_input_loader_pkg::*;
#(
    parameter int unsigned N_INPUTS = 2,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = $clog2(N_INPUTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_last,
    output logic                     mem_trig_w,
    output logic        [ADDR_W-1:0] mem_abus_w,
    output logic signed [DATA_W-1:0] mem_dbus_w,
    output logic                     net_req,
    input  logic                     net_ack,
    output logic                     busy,
    output logic                     done,
    output logic                     err_len
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

    state_t             state_q, state_n;
    logic  [ADDR_W-1:0] cnt_q, cnt_n;

    logic                     accept;
    logic                     at_last;
    logic                     s_ready_n;
    logic                     mem_trig_n;
    logic        [ADDR_W-1:0] mem_abus_n;
    logic signed [DATA_W-1:0] mem_dbus_n;
    logic                     net_req_n;
    logic                     busy_n;
    logic                     done_n;
    logic                     err_len_n;

    assign accept  = s_valid && s_ready;
    assign at_last = (cnt_q == LAST_ADDR);

    // State, address counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            s_ready    <= 1'b0;
            mem_trig_w <= 1'b0;
            mem_abus_w <= '0;
            mem_dbus_w <= '0;
            net_req    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            s_ready    <= s_ready_n;
            mem_trig_w <= mem_trig_n;
            mem_abus_w <= mem_abus_n;
            mem_dbus_w <= mem_dbus_n;
            net_req    <= net_req_n;
            busy       <= busy_n;
            done       <= done_n;
            err_len    <= err_len_n;
        end
    end

    // Next state and next write address.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                if (accept && !s_last) begin
                    state_n = ST_LOAD;
                    cnt_n   = ADDR_W'(1);
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (at_last) begin
                        state_n = s_last ? ST_REQ : ST_DRAIN;
                    end else if (s_last) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && s_last) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                // Only an acknowledge to a visible request completes the frame.
                if (net_ack && net_req) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Values the output registers take at the next edge.
    always_comb begin
        s_ready_n  = state_ready(state_n);
        busy_n     = (state_n != ST_IDLE);
        done_n     = (state_n == ST_DONE);
        net_req_n  = (state_q == ST_REQ) && !(net_ack && net_req);
        mem_trig_n = 1'b0;
        mem_abus_n = mem_abus_w;
        mem_dbus_n = mem_dbus_w;
        err_len_n  = 1'b0;

        if (accept && (state_q == ST_IDLE || state_q == ST_LOAD)) begin
            mem_trig_n = 1'b1;
            mem_abus_n = cnt_q;
            mem_dbus_n = s_data;
        end

        if (accept) begin
            if (state_q == ST_IDLE) begin
                err_len_n = s_last;
            end else if (state_q == ST_LOAD) begin
                err_len_n = at_last ? !s_last : s_last;
            end
        end
    end

endmodule

// File: tb/tb_nn_input_loader.sv
// Cycle-by-cycle directed check of nn_input_loader (N_INPUTS=2, DATA_W=8).
module tb_nn_input_loader;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic signed [7:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              mem_trig_w;
    logic        [0:0] mem_abus_w;
    logic signed [7:0] mem_dbus_w;
    logic              net_req;
    logic              net_ack = 1'b0;
    logic              busy;
    logic              done;
    logic              err_len;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nn_input_loader #(
        .N_INPUTS(2),
        .DATA_W  (8),
        .ADDR_W  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .mem_trig_w(mem_trig_w),
        .mem_abus_w(mem_abus_w),
        .mem_dbus_w(mem_dbus_w),
        .net_req   (net_req),
        .net_ack   (net_ack),
        .busy      (busy),
        .done      (done),
        .err_len   (err_len)
    );

    // ready, trig, addr, data, req, busy, done, err
    typedef struct packed {
        logic       rdy;
        logic       trig;
        logic [0:0] addr;
        logic [7:0] data;
        logic       req;
        logic       bsy;
        logic       dn;
        logic       err;
    } out_t;

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       a;
        out_t       exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic out_t o(input logic rdy, input logic trig, input logic addr,
                               input logic [7:0] data, input logic req, input logic bsy,
                               input logic dn, input logic err);
        out_t t;
        t.rdy  = rdy;
        t.trig = trig;
        t.addr = addr;
        t.data = data;
        t.req  = req;
        t.bsy  = bsy;
        t.dn   = dn;
        t.err  = err;
        return t;
    endfunction

    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic l,
                       input logic a, input out_t e, input string nm);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.l = l; x.a = a; x.exp = e; x.name = nm;
        vecs.push_back(x);
    endtask

    // Drive one cycle of inputs, then compare outputs just after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic l,
                        input logic a, input out_t e, input string nm);
        out_t got;
        @(negedge clk);
        rst     = r;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        net_ack = a;
        @(posedge clk);
        #1;
        got = o(s_ready, mem_trig_w, mem_abus_w[0], mem_dbus_w, net_req, busy, done, err_len);
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got rdy=%b trig=%b a=%b d=%h req=%b busy=%b done=%b err=%b, want rdy=%b trig=%b a=%b d=%h req=%b busy=%b done=%b err=%b",
                     nm, got.rdy, got.trig, got.addr, got.data, got.req, got.bsy, got.dn, got.err,
                     e.rdy, e.trig, e.addr, e.data, e.req, e.bsy, e.dn, e.err);
        end
    endtask

    initial begin
        // reset, nominal 12,12 frame with ack 4 cycles into the request
        add(1, 0, 8'd0,  0, 0, o(0, 0, 0, 8'd0,  0, 0, 0, 0), "reset");
        add(0, 0, 8'd0,  0, 0, o(1, 0, 0, 8'd0,  0, 0, 0, 0), "idle");
        add(0, 1, 8'd12, 0, 0, o(1, 1, 0, 8'd12, 0, 1, 0, 0), "nom_s0");
        add(0, 1, 8'd12, 1, 0, o(0, 1, 1, 8'd12, 0, 1, 0, 0), "nom_s1");
        add(0, 0, 8'd0,  0, 0, o(0, 0, 1, 8'd12, 1, 1, 0, 0), "nom_req");
        add(0, 0, 8'd0,  0, 0, o(0, 0, 1, 8'd12, 1, 1, 0, 0), "nom_hold1");
        add(0, 0, 8'd0,  0, 0, o(0, 0, 1, 8'd12, 1, 1, 0, 0), "nom_hold2");
        add(0, 0, 8'd0,  0, 0, o(0, 0, 1, 8'd12, 1, 1, 0, 0), "nom_hold3");
        add(0, 0, 8'd0,  0, 1, o(0, 0, 1, 8'd12, 0, 1, 1, 0), "nom_ack");
        add(0, 0, 8'd0,  0, 0, o(1, 0, 1, 8'd12, 0, 0, 0, 0), "nom_idle");
        // short frame: -3 with s_last on sample 0
        add(0, 1, 8'hFD, 1, 0, o(1, 1, 0, 8'hFD, 0, 0, 0, 1), "short_s0");
        add(0, 0, 8'd0,  0, 0, o(1, 0, 0, 8'hFD, 0, 0, 0, 0), "short_idle");
        add(0, 0, 8'd0,  0, 1, o(1, 0, 0, 8'hFD, 0, 0, 0, 0), "ack_in_idle");
        // long frame: 1,2,3,4 with s_last on 4
        add(0, 1, 8'd1,  0, 0, o(1, 1, 0, 8'd1,  0, 1, 0, 0), "long_s0");
        add(0, 1, 8'd2,  0, 0, o(1, 1, 1, 8'd2,  0, 1, 0, 1), "long_s1");
        add(0, 1, 8'd3,  0, 1, o(1, 0, 1, 8'd2,  0, 1, 0, 0), "long_drop3");
        add(0, 1, 8'd4,  1, 0, o(0, 0, 1, 8'd2,  0, 1, 0, 0), "long_drop4");
        add(0, 0, 8'd0,  0, 0, o(0, 0, 1, 8'd2,  1, 1, 0, 0), "long_req");
        add(0, 0, 8'd0,  0, 1, o(0, 0, 1, 8'd2,  0, 1, 1, 0), "long_ack");
        add(0, 0, 8'd0,  0, 0, o(1, 0, 1, 8'd2,  0, 0, 0, 0), "long_idle");

        rst = 1'b1;
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].a, vecs[i].exp, vecs[i].name);
        end

        // back-pressure: sample 99 held valid through REQ and DONE
        step(0, 1, 8'd5,   0, 0, o(1, 1, 0, 8'd5,   0, 1, 0, 0), "bp_s0");
        step(0, 1, 8'd6,   1, 0, o(0, 1, 1, 8'd6,   0, 1, 0, 0), "bp_s1");
        step(0, 1, 8'd99,  0, 0, o(0, 0, 1, 8'd6,   1, 1, 0, 0), "bp_hold_req1");
        step(0, 1, 8'd99,  0, 0, o(0, 0, 1, 8'd6,   1, 1, 0, 0), "bp_hold_req2");
        step(0, 1, 8'd99,  0, 1, o(0, 0, 1, 8'd6,   0, 1, 1, 0), "bp_ack");
        step(0, 1, 8'd99,  0, 0, o(1, 0, 1, 8'd6,   0, 0, 0, 0), "bp_hold_done");
        step(0, 1, 8'd99,  0, 0, o(1, 1, 0, 8'd99,  0, 1, 0, 0), "bp_accept");
        step(0, 1, 8'd100, 1, 0, o(0, 1, 1, 8'd100, 0, 1, 0, 0), "bp_s1b");
        step(0, 0, 8'd0,   0, 0, o(0, 0, 1, 8'd100, 1, 1, 0, 0), "bp_req");

        // reset while net_req is high; later acks must not produce done
        step(1, 0, 8'd0,   0, 0, o(0, 0, 0, 8'd0,   0, 0, 0, 0), "rst_mid_req");
        step(0, 0, 8'd0,   0, 1, o(1, 0, 0, 8'd0,   0, 0, 0, 0), "late_ack1");
        step(0, 0, 8'd0,   0, 1, o(1, 0, 0, 8'd0,   0, 0, 0, 0), "late_ack2");
        step(0, 0, 8'd0,   0, 0, o(1, 0, 0, 8'd0,   0, 0, 0, 0), "post_rst_idle");
        // reset wins over a valid sample in the same cycle
        step(1, 1, 8'd7,   0, 0, o(0, 0, 0, 8'd0,   0, 0, 0, 0), "rst_priority");
        step(0, 0, 8'd0,   0, 0, o(1, 0, 0, 8'd0,   0, 0, 0, 0), "rst_priority_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
